div_seq_32: RTL and testbench



---
 rtl/div_pkg.sv | 21 ++
 rtl/div_step_32.sv | 27 ++
 rtl/div_seq_32.sv | 130 +++++++++++++
 tb/tb_div_seq_32.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants, FSM state type and operand helper for the iterative divider.
package div_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;
    localparam int ITER  = 32;

    localparam logic [WIDTH-1:0] DIV0_QUO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    // Magnitude of a two's-complement value when signed; 0x80000000 maps to itself.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/div_step_32.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step_32
    import div_pkg::*;
(
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] rem_q;
    logic [WIDTH:0] diff;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        rem_q    = {rem, bit_in};
        diff     = rem_q - {1'b0, divisor};
        q_bit    = 1'b0;
        rem_next = rem_q[WIDTH-1:0];
        if (rem_q >= {1'b0, divisor}) begin
            q_bit    = 1'b1;
            rem_next = diff[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/div_seq_32.sv
// Multi-cycle DIV/DIVU unit: quotient to lo, remainder to hi, one quotient bit per clock.
// Optional macro DIV_ZERO_FAST_EN adds div_by_zero and a two-cycle divide-by-zero path.
module div_seq_32
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
`ifdef DIV_ZERO_FAST_EN
    ,
    output logic             div_by_zero
`endif
);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] a_hold;
    logic             qneg;
    logic             rneg;
    logic             b_zero;

    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] fin_lo;
    logic [WIDTH-1:0] fin_hi;

    div_step_32 u_step (
        .rem      (rem),
        .bit_in   (quo[WIDTH-1]),
        .divisor  (divisor),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign quo_next = {quo[WIDTH-2:0], q_bit};

    // Results are taken from the last iteration's outputs so lo/hi land together with done.
    always_comb begin
        fin_lo = qneg ? -quo_next : quo_next;
        fin_hi = rneg ? -rem_next : rem_next;
        if (b_zero) begin
            fin_lo = DIV0_QUO;
            fin_hi = a_hold;
        end
    end

    // NOTE: all state here is sequential, so it uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            a_hold  <= '0;
            qneg    <= 1'b0;
            rneg    <= 1'b0;
            b_zero  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            lo      <= '0;
            hi      <= '0;
`ifdef DIV_ZERO_FAST_EN
            div_by_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
            div_by_zero <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        rem     <= '0;
                        quo     <= mag(a, is_signed);
                        divisor <= mag(b, is_signed);
                        a_hold  <= a;
                        qneg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rneg    <= is_signed & a[WIDTH-1];
                        b_zero  <= (b == '0);
                        cnt     <= CNT_W'(ITER);
                        busy    <= 1'b1;
`ifdef DIV_ZERO_FAST_EN
                        state   <= (b == '0) ? FIN : RUN;
`else
                        state   <= RUN;
`endif
                    end
                end
                RUN: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= FIN;
                        lo    <= fin_lo;
                        hi    <= fin_hi;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
`ifdef DIV_ZERO_FAST_EN
                    // Only the short-circuit path reaches FIN with b_zero set.
                    if (b_zero) begin
                        lo          <= DIV0_QUO;
                        hi          <= a_hold;
                        done        <= 1'b1;
                        div_by_zero <= 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_32.sv
// Self-checking bench for div_seq_32: arithmetic/timing model plus directed literal vectors.
module tb_div_seq_32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] lo;
    logic [31:0] hi;
`ifdef DIV_ZERO_FAST_EN
    logic        div_by_zero;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    div_seq_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .lo        (lo),
        .hi        (hi)
`ifdef DIV_ZERO_FAST_EN
        ,
        .div_by_zero (div_by_zero)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of DIV/DIVU using plain integer arithmetic.
    function automatic void model_div(input logic s, input logic [31:0] x, input logic [31:0] y,
                                      output logic [31:0] q, output logic [31:0] r);
        longint sx, sy;
        if (y == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = x;
        end else if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            q  = 32'(sx / sy);
            r  = 32'(sx % sy);
        end else begin
            q = x / y;
            r = x % y;
        end
    endfunction

    // Cycle-level expectation: age counts edges since acceptance.
    logic        e_busy = 1'b0, e_done = 1'b0, e_dz = 1'b0;
    logic [31:0] e_lo = '0, e_hi = '0;
    logic        m_active = 1'b0, m_fast = 1'b0, m_s = 1'b0;
    logic [31:0] m_a = '0, m_b = '0;
    int          m_age = 0;

    always @(posedge clk) begin
        e_done = 1'b0;
        e_dz   = 1'b0;
        if (!rst_n) begin
            m_active = 1'b0;
            e_busy   = 1'b0;
            e_lo     = '0;
            e_hi     = '0;
        end else if (m_active) begin
            m_age++;
            if (m_fast) begin
                e_busy   = 1'b0;
                e_done   = 1'b1;
                e_dz     = 1'b1;
                model_div(m_s, m_a, m_b, e_lo, e_hi);
                m_active = 1'b0;
            end else begin
                e_busy = (m_age <= 32);
                if (m_age == 32) begin
                    e_done = 1'b1;
                    model_div(m_s, m_a, m_b, e_lo, e_hi);
                end
                if (m_age == 33) m_active = 1'b0;
            end
        end else if (start) begin
            m_active = 1'b1;
            m_age    = 0;
            m_s      = is_signed;
            m_a      = a;
            m_b      = b;
`ifdef DIV_ZERO_FAST_EN
            m_fast   = (b == 32'h0);
`else
            m_fast   = 1'b0;
`endif
            e_busy   = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n !== 1'bx) begin
            check("mdl_busy", {31'b0, busy}, {31'b0, e_busy});
            check("mdl_done", {31'b0, done}, {31'b0, e_done});
            check("mdl_lo", lo, e_lo);
            check("mdl_hi", hi, e_hi);
`ifdef DIV_ZERO_FAST_EN
            check("mdl_dz", {31'b0, div_by_zero}, {31'b0, e_dz});
`endif
        end
    end

    // Issue one divide from just after a negedge; returns one negedge after done.
    task automatic run_div(input logic s, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] el, input logic [31:0] eh, input string nm);
        int  k, busy_n, exp_lat, exp_busy;
        bit  seen;
        exp_lat  = 33;
        exp_busy = 33;
`ifdef DIV_ZERO_FAST_EN
        if (y == 32'h0) begin
            exp_lat  = 2;
            exp_busy = 1;
        end
`endif
        is_signed = s;
        a         = x;
        b         = y;
        start     = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        k      = 1;
        busy_n = 0;
        seen   = 1'b0;
        while (k <= 40 && !seen) begin
            if (busy) busy_n++;
            if (done) begin
                seen = 1'b1;
                check({nm, "_latency"}, 32'(k), 32'(exp_lat));
                check({nm, "_lo"}, lo, el);
                check({nm, "_hi"}, hi, eh);
`ifdef DIV_ZERO_FAST_EN
                check({nm, "_dz"}, {31'b0, div_by_zero}, {31'b0, (y == 32'h0)});
`endif
            end else begin
                @(negedge clk);
                k++;
            end
        end
        if (!seen) check({nm, "_timeout"}, 32'd0, 32'd1);
        check({nm, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
        @(negedge clk);
    endtask

    initial begin
        int n_done, done_k;
        rst_n = 1'b0;
        start = 1'b0;
        is_signed = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_hi", hi, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_div(1'b0, 32'd100, 32'd7, 32'h0000_000E, 32'h0000_0002, "divu_100_7");
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_m7_2");
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, "div_7_m2");
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, "div_ovf");
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "divu_big");
        run_div(1'b1, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678, "div_zero_s");
        run_div(1'b0, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678, "div_zero_u");
        run_div(1'b1, 32'h8765_4321, 32'h0, 32'hFFFF_FFFF, 32'h8765_4321, "div_zero_neg");

        // Starts during a run must be ignored; a start right after done is accepted.
        is_signed = 1'b0;
        a = 32'd100;
        b = 32'd7;
        start = 1'b1;
        @(negedge clk);
        n_done = 0;
        done_k = 0;
        for (int k = 1; k <= 33; k++) begin
            if (done) begin
                n_done++;
                done_k = k;
            end
            start     = (k == 5 || k == 20);
            is_signed = (k == 5 || k == 20);
            a         = (k == 5 || k == 20) ? 32'd1 : 32'd100;
            b         = (k == 5 || k == 20) ? 32'd1 : 32'd7;
            @(negedge clk);
        end
        check("ign_done_count", 32'(n_done), 32'd1);
        check("ign_done_cycle", 32'(done_k), 32'd33);
        check("ign_lo", lo, 32'h0000_000E);
        check("ign_hi", hi, 32'h0000_0002);
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, "b2b_m100_7");

        // Reset in the middle of a run discards it without a done pulse.
        is_signed = 1'b0;
        a = 32'd100;
        b = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_lo", lo, 32'd0);
        check("midrst_hi", hi, 32'd0);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("midrst_no_done", 32'(n_done), 32'd0);
        run_div(1'b0, 32'd100, 32'd7, 32'h0000_000E, 32'h0000_0002, "after_rst");

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
